datapath_regbank: RTL and testbench

- Register bank and bus driver directly upstream/downstream of the 17-bit ALU in the downsampling processor datapath.
- Drives the ALU A operand (always AC) and B operand (muxed register), captures the ALU result Cbus into selected registers, and latches the ALU z output into a zero flag.
- Also holds AR/PC address registers with increment, and DR loaded from data memory; all control comes from the control unit one cycle ahead.

---
 rtl/datapath_regbank.sv | 166 ++++++++++++++++
 tb/tb_datapath_regbank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_regbank.sv
// Register bank around the 17-bit ALU of the downsampling datapath.
// Holds AC, R1-R3, TR, DR (data width) plus AR/PC (address width) and the
// zero flag. It feeds the ALU operands and captures the ALU result. The
// operand buses are driven only from register state, so the
// ALU -> cbus -> register -> abus/bbus loop is always broken by a flop.
module datapath_regbank #(
    parameter int DW = 17,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] cbus,
    input  logic          z_in,
    input  logic          z_en,
    input  logic [DW-1:0] dm_in,
    input  logic          dr_load_mem,
    input  logic [7:0]    wr_en,
    input  logic [4:0]    inc_en,
    input  logic [2:0]    bbus_sel,
    output logic [DW-1:0] abus,
    output logic [DW-1:0] bbus,
    output logic          z_flag,
    output logic [AW-1:0] ar_out,
    output logic [AW-1:0] pc_out,
    output logic [DW-1:0] dr_out
);

    logic [DW-1:0] ac_r, r1_r, r2_r, r3_r, tr_r, dr_r;
    logic [AW-1:0] ar_r, pc_r;
    logic          z_flag_r;

    logic [DW-1:0] ac_nxt_s, r1_nxt_s, r2_nxt_s, r3_nxt_s, tr_nxt_s, dr_nxt_s;
    logic [AW-1:0] ar_nxt_s, pc_nxt_s;
    logic          z_nxt_s;
    logic [DW-1:0] bbus_s;

    // Next-state per register: memory load beats bus write, bus write beats increment.
    always_comb begin
        ac_nxt_s = ac_r;
        r1_nxt_s = r1_r;
        r2_nxt_s = r2_r;
        r3_nxt_s = r3_r;
        tr_nxt_s = tr_r;
        dr_nxt_s = dr_r;
        ar_nxt_s = ar_r;
        pc_nxt_s = pc_r;
        z_nxt_s  = z_flag_r;

        if (wr_en[0]) begin
            ac_nxt_s = cbus;
        end else begin
            ac_nxt_s = ac_r;
        end

        if (wr_en[1]) begin
            r1_nxt_s = cbus;
        end else if (inc_en[2]) begin
            r1_nxt_s = r1_r + DW'(1);
        end else begin
            r1_nxt_s = r1_r;
        end

        if (wr_en[2]) begin
            r2_nxt_s = cbus;
        end else if (inc_en[3]) begin
            r2_nxt_s = r2_r + DW'(1);
        end else begin
            r2_nxt_s = r2_r;
        end

        if (wr_en[3]) begin
            r3_nxt_s = cbus;
        end else if (inc_en[4]) begin
            r3_nxt_s = r3_r + DW'(1);
        end else begin
            r3_nxt_s = r3_r;
        end

        if (wr_en[4]) begin
            tr_nxt_s = cbus;
        end else begin
            tr_nxt_s = tr_r;
        end

        // Address registers drop the ALU result MSB.
        if (wr_en[5]) begin
            ar_nxt_s = cbus[AW-1:0];
        end else if (inc_en[0]) begin
            ar_nxt_s = ar_r + AW'(1);
        end else begin
            ar_nxt_s = ar_r;
        end

        if (wr_en[6]) begin
            pc_nxt_s = cbus[AW-1:0];
        end else if (inc_en[1]) begin
            pc_nxt_s = pc_r + AW'(1);
        end else begin
            pc_nxt_s = pc_r;
        end

        if (dr_load_mem) begin
            dr_nxt_s = dm_in;
        end else if (wr_en[7]) begin
            dr_nxt_s = cbus;
        end else begin
            dr_nxt_s = dr_r;
        end

        // z_in reflects the operands presented this cycle, i.e. pre-write state.
        if (z_en) begin
            z_nxt_s = z_in;
        end else begin
            z_nxt_s = z_flag_r;
        end
    end

    // State registers with synchronous reset that discards any same-cycle update.
    always_ff @(posedge clk) begin
        if (rst) begin
            ac_r     <= '0;
            r1_r     <= '0;
            r2_r     <= '0;
            r3_r     <= '0;
            tr_r     <= '0;
            dr_r     <= '0;
            ar_r     <= '0;
            pc_r     <= '0;
            z_flag_r <= 1'b0;
        end else begin
            ac_r     <= ac_nxt_s;
            r1_r     <= r1_nxt_s;
            r2_r     <= r2_nxt_s;
            r3_r     <= r3_nxt_s;
            tr_r     <= tr_nxt_s;
            dr_r     <= dr_nxt_s;
            ar_r     <= ar_nxt_s;
            pc_r     <= pc_nxt_s;
            z_flag_r <= z_nxt_s;
        end
    end

    // B operand mux, sourced from registers only (never from cbus).
    always_comb begin
        bbus_s = '0;
        case (bbus_sel)
            3'd0:    bbus_s = dr_r;
            3'd1:    bbus_s = r1_r;
            3'd2:    bbus_s = r2_r;
            3'd3:    bbus_s = r3_r;
            3'd4:    bbus_s = tr_r;
            3'd5:    bbus_s = {{(DW-AW){1'b0}}, ar_r};
            3'd6:    bbus_s = {{(DW-AW){1'b0}}, pc_r};
            3'd7:    bbus_s = '0;
            default: bbus_s = '0;
        endcase
    end

    assign abus   = ac_r;
    assign bbus   = bbus_s;
    assign z_flag = z_flag_r;
    assign ar_out = ar_r;
    assign pc_out = pc_r;
    assign dr_out = dr_r;

endmodule

// File: tb/tb_datapath_regbank.sv
// Scoreboard bench for datapath_regbank: a driver updates an array-based
// reference model and queues the expected post-edge view; a monitor pops and
// compares after each rising edge. A bench-side ALU closes the cbus loop.
module tb_datapath_regbank;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] cbus;
    logic        z_in;
    logic        z_en;
    logic [16:0] dm_in;
    logic        dr_load_mem;
    logic [7:0]  wr_en;
    logic [4:0]  inc_en;
    logic [2:0]  bbus_sel;
    logic [16:0] abus, bbus, dr_out;
    logic        z_flag;
    logic [15:0] ar_out, pc_out;

    // Bench-side ALU and cbus source selection.
    logic        alu_mode;
    logic [1:0]  alu_op;
    logic [16:0] cbus_drv;
    logic        z_drv;
    logic [16:0] alu_res;

    localparam logic [1:0] OP_PAS = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2;

    function automatic logic [16:0] alu_f(input logic [1:0] op, input logic [16:0] a, input logic [16:0] b);
        case (op)
            OP_ADD:  return 17'((int'(a) + int'(b)) % 131072);
            OP_SUB:  return 17'((int'(a) - int'(b) + 131072) % 131072);
            default: return b;
        endcase
    endfunction

    assign alu_res = alu_f(alu_op, abus, bbus);
    assign cbus    = alu_mode ? alu_res : cbus_drv;
    assign z_in    = alu_mode ? (alu_res == 17'd0) : z_drv;

    datapath_regbank #(.DW(17), .AW(16)) dut (
        .clk(clk), .rst(rst), .cbus(cbus), .z_in(z_in), .z_en(z_en),
        .dm_in(dm_in), .dr_load_mem(dr_load_mem), .wr_en(wr_en),
        .inc_en(inc_en), .bbus_sel(bbus_sel), .abus(abus), .bbus(bbus),
        .z_flag(z_flag), .ar_out(ar_out), .pc_out(pc_out), .dr_out(dr_out)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 AC,1 R1,2 R2,3 R3,4 TR,5 AR,6 PC,7 DR.
    logic [16:0] m [8];
    logic        mz;

    typedef struct {
        logic [16:0] abus;
        logic [16:0] bbus;
        logic [15:0] ar;
        logic [15:0] pc;
        logic [16:0] dr;
        logic        z;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    function automatic logic [16:0] width_mask(input int i);
        return (i == 5 || i == 6) ? 17'h0FFFF : 17'h1FFFF;
    endfunction

    // Which inc_en bit increments register i (-1 when none).
    function automatic int inc_bit(input int i);
        case (i)
            5: return 0;
            6: return 1;
            1: return 2;
            2: return 3;
            3: return 4;
            default: return -1;
        endcase
    endfunction

    function automatic logic [16:0] sel_val(input logic [2:0] s);
        case (s)
            3'd0: return m[7];
            3'd1: return m[1];
            3'd2: return m[2];
            3'd3: return m[3];
            3'd4: return m[4];
            3'd5: return m[5];
            3'd6: return m[6];
            default: return 17'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, update the model, queue expectation.
    task automatic step(input logic r, input logic amode, input logic [1:0] op,
                        input logic [16:0] cb, input logic zi, input logic ze,
                        input logic [16:0] dm, input logic drl, input logic [7:0] wr,
                        input logic [4:0] inc, input logic [2:0] sel);
        exp_t e;
        logic [16:0] c;
        logic [16:0] nv [8];
        logic        zv;
        @(negedge clk);
        rst = r; alu_mode = amode; alu_op = op; cbus_drv = cb; z_drv = zi;
        z_en = ze; dm_in = dm; dr_load_mem = drl; wr_en = wr; inc_en = inc;
        bbus_sel = sel;
        if (amode) begin
            c  = alu_f(op, m[0], sel_val(sel));
            zv = (c == 17'd0);
        end else begin
            c  = cb;
            zv = zi;
        end
        for (int i = 0; i < 8; i++) begin
            if (r) nv[i] = 17'd0;
            else if (i == 7 && drl) nv[i] = dm;
            else if (wr[i]) nv[i] = c & width_mask(i);
            else if (inc_bit(i) >= 0 && inc[inc_bit(i)]) nv[i] = (m[i] + 17'd1) & width_mask(i);
            else nv[i] = m[i];
        end
        for (int i = 0; i < 8; i++) m[i] = nv[i];
        if (r) mz = 1'b0;
        else if (ze) mz = zv;
        e.abus = m[0];
        e.bbus = sel_val(sel);
        e.ar   = m[5][15:0];
        e.pc   = m[6][15:0];
        e.dr   = m[7];
        e.z    = mz;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic wr(input logic [16:0] cb, input logic [7:0] w, input logic [2:0] sel);
        step(1'b0, 1'b0, OP_PAS, cb, 1'b0, 1'b0, 17'd0, 1'b0, w, 5'd0, sel);
    endtask

    // Monitor: compare the DUT view against the oldest queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("abus",   abus,           e.abus);
                check("bbus",   bbus,           e.bbus);
                check("ar_out", {1'b0, ar_out}, {1'b0, e.ar});
                check("pc_out", {1'b0, pc_out}, {1'b0, e.pc});
                check("dr_out", dr_out,         e.dr);
                check("z_flag", {16'd0, z_flag}, {16'd0, e.z});
            end
        end
    end

    initial begin
        rst = 1'b1; alu_mode = 1'b0; alu_op = OP_PAS; cbus_drv = 17'd0; z_drv = 1'b0;
        z_en = 1'b0; dm_in = 17'd0; dr_load_mem = 1'b0; wr_en = 8'd0; inc_en = 5'd0;
        bbus_sel = 3'd0;
        for (int i = 0; i < 8; i++) m[i] = 17'd0;
        mz = 1'b0;

        // Reset from power-up, preload everything, then reset under a full write.
        step(1'b1, 1'b0, OP_PAS, 17'd0, 1'b0, 1'b0, 17'd0, 1'b0, 8'h00, 5'd0, 3'd0);
        step(1'b0, 1'b0, OP_PAS, 17'h1ABCD, 1'b1, 1'b1, 17'd0, 1'b0, 8'hFF, 5'd0, 3'd1);
        step(1'b1, 1'b0, OP_PAS, 17'h1ABCD, 1'b1, 1'b1, 17'h1ABCD, 1'b1, 8'hFF, 5'h1F, 3'd1);
        step(1'b1, 1'b0, OP_PAS, 17'h1ABCD, 1'b1, 1'b1, 17'h1ABCD, 1'b1, 8'hFF, 5'h1F, 3'd4);

        // Broadcast write then sweep the B mux.
        wr(17'h1F00F, 8'b0111_1110, 3'd1);
        for (int s = 1; s < 8; s++) wr(17'h0, 8'h00, 3'(s));

        // Increment wrap on AR and R2; PC untouched.
        wr(17'h0FFFF, 8'b0010_0000, 3'd5);
        wr(17'h1FFFF, 8'b0000_0100, 3'd2);
        step(1'b0, 1'b0, OP_PAS, 17'd0, 1'b0, 1'b0, 17'd0, 1'b0, 8'h00, 5'b01001, 3'd2);
        wr(17'h0, 8'h00, 3'd5);

        // Write beats increment on PC; memory load beats write on DR.
        wr(17'h00005, 8'b0100_0000, 3'd6);
        step(1'b0, 1'b0, OP_PAS, 17'h00100, 1'b0, 1'b0, 17'd0, 1'b0, 8'b0100_0000, 5'b00010, 3'd6);
        step(1'b0, 1'b0, OP_PAS, 17'h00011, 1'b0, 1'b0, 17'h00077, 1'b1, 8'b1000_0000, 5'd0, 3'd0);

        // Zero flag hold/load behaviour.
        step(1'b0, 1'b0, OP_PAS, 17'd0, 1'b0, 1'b1, 17'd0, 1'b0, 8'h00, 5'd0, 3'd7);
        step(1'b0, 1'b0, OP_PAS, 17'd0, 1'b1, 1'b0, 17'd0, 1'b0, 8'h00, 5'd0, 3'd7);
        step(1'b0, 1'b0, OP_PAS, 17'd0, 1'b1, 1'b1, 17'd0, 1'b0, 8'h00, 5'd0, 3'd7);
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b0, OP_PAS, 17'd0, 1'b0, 1'b0, 17'd0, 1'b0, 8'h00, 5'd0, 3'd7);

        // ALU loop: AC=3, R1=2, ADD -> 5, then SUB -> 3, 1, 1FFFF with z latched.
        wr(17'd3, 8'b0000_0001, 3'd1);
        wr(17'd2, 8'b0000_0010, 3'd1);
        step(1'b0, 1'b1, OP_ADD, 17'd0, 1'b0, 1'b1, 17'd0, 1'b0, 8'b0000_0001, 5'd0, 3'd1);
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b1, OP_SUB, 17'd0, 1'b0, 1'b1, 17'd0, 1'b0, 8'b0000_0001, 5'd0, 3'd1);
        // Move AC-independent source TR->R3 via PAS, and a zero result into z.
        step(1'b0, 1'b1, OP_PAS, 17'd0, 1'b0, 1'b1, 17'd0, 1'b0, 8'b0000_1000, 5'd0, 3'd4);
        step(1'b0, 1'b1, OP_PAS, 17'd0, 1'b0, 1'b1, 17'd0, 1'b0, 8'b0000_0000, 5'd0, 3'd7);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            step(($urandom % 40) == 0, $urandom % 2 == 0, 2'($urandom % 3),
                 17'($urandom), 1'($urandom), 1'($urandom), 17'($urandom),
                 ($urandom % 4) == 0, 8'($urandom) & 8'($urandom), 5'($urandom),
                 3'($urandom));
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
